// File: rtl/sobel_kernel.sv
// sobel_kernel: streaming 3x3 Sobel edge magnitude over a column-fed window, fixed 2-cycle latency.
// Defining SOBEL_THRESH_EN binarises pix_out against THRESH (255 at/above, 0 below).
module sobel_kernel #(
    parameter logic [7:0] THRESH = 8'd64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       line_start,
    input  logic       col_valid,
    input  logic [7:0] px_top,
    input  logic [7:0] px_mid,
    input  logic [7:0] px_bot,
    output logic [7:0] pix_out,
    output logic       pix_valid,
    output logic [6:0] out_col
);

`ifdef SOBEL_THRESH_EN
    localparam logic THRESH_EN = 1'b1;
`else
    localparam logic THRESH_EN = 1'b0;
`endif

    function automatic logic [10:0] f_wsum(input logic [7:0] a, input logic [7:0] m, input logic [7:0] b);
        return {3'b000, a} + {2'b00, m, 1'b0} + {3'b000, b};
    endfunction

    function automatic logic [10:0] f_abs(input logic [10:0] v);
        return v[10] ? (11'd0 - v) : v;
    endfunction

    // Columns are packed {t, m, b}; c0 is the oldest column of the window.
    logic [23:0] r_c0, r_c1, r_c2;
    logic [1:0]  r_fill;
    logic [6:0]  r_col_cnt;
    logic [6:0]  r_win_col;
    logic        r_win_valid;

    logic [10:0] w_gx, w_gy, w_gx_abs, w_gy_abs;
    logic [11:0] w_mag;
    logic [7:0]  w_sat, w_pix;

    // Window shift, per-line fill tracking and output column numbering.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_c0        <= 24'd0;
            r_c1        <= 24'd0;
            r_c2        <= 24'd0;
            r_fill      <= 2'd0;
            r_col_cnt   <= 7'd0;
            r_win_col   <= 7'd0;
            r_win_valid <= 1'b0;
        end else begin
            r_win_valid <= 1'b0;
            if (col_valid) begin
                r_c0 <= r_c1;
                r_c1 <= r_c2;
                r_c2 <= {px_top, px_mid, px_bot};
            end
            if (line_start) begin
                r_col_cnt <= 7'd0;
                r_fill    <= col_valid ? 2'd1 : 2'd0;
            end else if (col_valid) begin
                if (r_fill == 2'd2) begin
                    r_win_valid <= 1'b1;
                    r_win_col   <= r_col_cnt + 7'd1;
                    r_col_cnt   <= r_col_cnt + 7'd1;
                end else begin
                    r_fill <= r_fill + 2'd1;
                end
            end
        end
    end

    // Gradients, magnitude, saturation and optional binarisation of the current window.
    always_comb begin
        w_gx     = f_wsum(r_c2[23:16], r_c2[15:8], r_c2[7:0]) - f_wsum(r_c0[23:16], r_c0[15:8], r_c0[7:0]);
        w_gy     = f_wsum(r_c0[23:16], r_c1[23:16], r_c2[23:16]) - f_wsum(r_c0[7:0], r_c1[7:0], r_c2[7:0]);
        w_gx_abs = f_abs(w_gx);
        w_gy_abs = f_abs(w_gy);
        w_mag    = {1'b0, w_gx_abs} + {1'b0, w_gy_abs};
        if (w_mag > 12'd255) begin
            w_sat = 8'hFF;
        end else begin
            w_sat = w_mag[7:0];
        end
        if (THRESH_EN) begin
            if (w_sat >= THRESH) begin
                w_pix = 8'hFF;
            end else begin
                w_pix = 8'h00;
            end
        end else begin
            w_pix = w_sat;
        end
    end

    // Output register; a result already in flight keeps its own column index across line_start.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pix_out   <= 8'd0;
            pix_valid <= 1'b0;
            out_col   <= 7'd0;
        end else if (r_win_valid) begin
            pix_out   <= w_pix;
            pix_valid <= 1'b1;
            out_col   <= r_win_col;
        end else begin
            pix_valid <= 1'b0;
            if (line_start) begin
                out_col <= 7'd0;
            end
        end
    end

endmodule

// File: tb/tb_sobel_kernel.sv
// tb_sobel_kernel: table vectors, directed corner sequences and random traffic against a
// column-list reference model of the Sobel kernel.
`timescale 1ns/1ps
module tb_sobel_kernel;

    logic       clk;
    logic       rst;
    logic       line_start;
    logic       col_valid;
    logic [7:0] px_top, px_mid, px_bot;
    logic [7:0] pix_out;
    logic       pix_valid;
    logic [6:0] out_col;

    sobel_kernel dut (
        .clk        (clk),
        .rst        (rst),
        .line_start (line_start),
        .col_valid  (col_valid),
        .px_top     (px_top),
        .px_mid     (px_mid),
        .px_bot     (px_bot),
        .pix_out    (pix_out),
        .pix_valid  (pix_valid),
        .out_col    (out_col)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { int t; int m; int b; } col_t;
    typedef struct { int pix; int col; int due; } exp_t;
    typedef struct { logic [71:0] cols; int exp; } vec_t;

    col_t line_q[$];
    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   line_out = 0;
    int   last_pix = 0;
    int   pulses = 0;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic int thr(input int s);
`ifdef SOBEL_THRESH_EN
        return (s >= 64) ? 255 : 0;
`else
        return s;
`endif
    endfunction

    function automatic int ref_pix(input col_t a, input col_t b, input col_t c);
        int gx, gy, mag;
        gx  = (c.t + 2 * c.m + c.b) - (a.t + 2 * a.m + a.b);
        gy  = (a.t + 2 * b.t + c.t) - (a.b + 2 * b.b + c.b);
        mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
        return thr(mag > 255 ? 255 : mag);
    endfunction

    task automatic cycle(input bit ls, input bit cv, input logic [7:0] t, input logic [7:0] m, input logic [7:0] b);
        col_t c;
        exp_t e;
        bit   ev;
        line_start = ls;
        col_valid  = cv;
        px_top = t;
        px_mid = m;
        px_bot = b;
        @(posedge clk);
        #1;
        cyc++;
        if (ls) begin
            line_q.delete();
            line_out = 0;
        end
        if (cv) begin
            c.t = int'(t); c.m = int'(m); c.b = int'(b);
            line_q.push_back(c);
            if (line_q.size() > 3) void'(line_q.pop_front());
            if (line_q.size() == 3) begin
                line_out = (line_out + 1) % 128;
                e.pix = ref_pix(line_q[0], line_q[1], line_q[2]);
                e.col = line_out;
                e.due = cyc + 1;
                exp_q.push_back(e);
            end
        end
        ev = (exp_q.size() > 0) && (exp_q[0].due == cyc);
        check("pix_valid", int'(pix_valid), int'(ev));
        if (ev) begin
            e = exp_q.pop_front();
            check("pix_out", int'(pix_out), e.pix);
            check("out_col", int'(out_col), e.col);
            last_pix = e.pix;
        end else begin
            check("pix_hold", int'(pix_out), last_pix);
        end
        if (pix_valid) pulses++;
    endtask

    task automatic do_reset();
        line_start = 1'b0;
        col_valid  = 1'b0;
        rst = 1'b0;
        #1;
        check("rst_pix_out", int'(pix_out), 0);
        check("rst_pix_valid", int'(pix_valid), 0);
        check("rst_out_col", int'(out_col), 0);
        line_q.delete();
        exp_q.delete();
        line_out = 0;
        last_pix = 0;
        @(posedge clk);
        #1;
        cyc++;
        check("rst_no_valid", int'(pix_valid), 0);
        rst = 1'b1;
    endtask

    initial begin
        vec_t vecs[6];
        logic [7:0] p[9];
        rst = 1'b1;
        line_start = 1'b0;
        col_valid = 1'b0;
        px_top = 8'd0; px_mid = 8'd0; px_bot = 8'd0;
        #2 rst = 1'b0;
        #1;
        check("init_pix_out", int'(pix_out), 0);
        check("init_pix_valid", int'(pix_valid), 0);
        check("init_out_col", int'(out_col), 0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;

        // {c0 t,m,b, c1 t,m,b, c2 t,m,b}, expected saturated magnitude
        vecs[0] = '{cols: {8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd255, 8'd255, 8'd255}, exp: 255};
        vecs[1] = '{cols: {8'd10, 8'd10, 8'd10, 8'd20, 8'd20, 8'd20, 8'd30, 8'd30, 8'd30}, exp: 80};
        vecs[2] = '{cols: {8'd255, 8'd0, 8'd0, 8'd255, 8'd0, 8'd0, 8'd255, 8'd0, 8'd0}, exp: 255};
        vecs[3] = '{cols: {8'd100, 8'd100, 8'd100, 8'd100, 8'd100, 8'd100, 8'd100, 8'd100, 8'd100}, exp: 0};
        vecs[4] = '{cols: {8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd10, 8'd0, 8'd0}, exp: 20};
        vecs[5] = '{cols: {8'd20, 8'd5, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0}, exp: 50};
        for (int i = 0; i < 6; i++) begin
            for (int k = 0; k < 9; k++) p[k] = vecs[i].cols[71 - 8 * k -: 8];
            cycle(1'b1, 1'b1, p[0], p[1], p[2]);
            cycle(1'b0, 1'b1, p[3], p[4], p[5]);
            cycle(1'b0, 1'b1, p[6], p[7], p[8]);
            cycle(1'b0, 1'b0, 8'hA5, 8'h5A, 8'hFF);
            check("vec_valid", int'(pix_valid), 1);
            check("vec_pix", int'(pix_out), thr(vecs[i].exp));
            cycle(1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
        end

        // Uniform field: ten back-to-back columns give eight outputs.
        pulses = 0;
        cycle(1'b1, 1'b1, 8'd100, 8'd100, 8'd100);
        for (int i = 1; i < 10; i++) cycle(1'b0, 1'b1, 8'd100, 8'd100, 8'd100);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
        check("uniform_pulses", pulses, 8);

        // line_start on the 4th column: one old-line output, then new line's first at out_col 1.
        pulses = 0;
        cycle(1'b1, 1'b1, 8'd10, 8'd10, 8'd10);
        cycle(1'b0, 1'b1, 8'd20, 8'd20, 8'd20);
        cycle(1'b0, 1'b1, 8'd30, 8'd30, 8'd30);
        cycle(1'b1, 1'b1, 8'd0, 8'd0, 8'd0);
        cycle(1'b0, 1'b1, 8'd0, 8'd0, 8'd0);
        cycle(1'b0, 1'b1, 8'd255, 8'd255, 8'd255);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
        check("newline_pulses", pulses, 2);

        // Reset between qualifying columns flushes the in-flight result.
        cycle(1'b1, 1'b1, 8'd0, 8'd0, 8'd0);
        cycle(1'b0, 1'b1, 8'd0, 8'd0, 8'd0);
        cycle(1'b0, 1'b1, 8'd200, 8'd200, 8'd200);
        do_reset();
        pulses = 0;
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
        check("flush_pulses", pulses, 0);

        // Long line so out_col wraps 127 -> 0.
        cycle(1'b1, 1'b1, 8'($urandom), 8'($urandom), 8'($urandom));
        for (int i = 1; i < 140; i++) cycle(1'b0, 1'b1, 8'($urandom), 8'($urandom), 8'($urandom));

        // Random traffic with sporadic line starts, idle gaps and resets.
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 249) == 0) do_reset();
            cycle(($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0),
                  8'($urandom), 8'($urandom), 8'($urandom));
        end
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
        check("drain", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
